pipelined_segment_adder: RTL and testbench



---
 rtl/pipelined_segment_adder.sv | 144 ++++++++++++++
 tb/tb_pipelined_segment_adder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_segment_adder.sv
// pipelined_segment_adder
// WIDTH-bit add/subtract split into NSEG = WIDTH/SEG_WIDTH ripple segments.
// Each pipeline rank adds one segment and registers its carry for the next
// rank. Operand bits that have not been added yet, and sum bits that are
// already finished, travel with the beat.
//
// Handshake: a beat transfers in when in_valid & in_ready, and transfers out
// when out_valid & out_ready. The pipe advances as a whole when the output
// register is empty or is being drained (advance = !out_valid | out_ready).
// in_ready equals advance and never depends on in_valid. When the pipe is not
// advancing, every rank holds its contents.
module pipelined_segment_adder #(
   parameter int WIDTH     = 16,
   parameter int SEG_WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             ovf
);

   localparam int NSEG = WIDTH / SEG_WIDTH;

   // Bit-serial ripple over one segment.
   // Returns {carry into segment MSB, carry out, segment sum}.
   function automatic logic [SEG_WIDTH+1:0] seg_add(
      input logic [SEG_WIDTH-1:0] x,
      input logic [SEG_WIDTH-1:0] y,
      input logic                 ci
   );
      logic [SEG_WIDTH-1:0] s;
      logic                 cy;
      logic                 cm;
      s  = '0;
      cy = ci;
      cm = 1'b0;
      for (int i = 0; i < SEG_WIDTH; i++) begin
         if (i == SEG_WIDTH - 1) cm = cy;
         s[i] = x[i] ^ y[i] ^ cy;
         cy   = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
      end
      return {cm, cy, s};
   endfunction

   // Per-rank pipeline state.
   logic [WIDTH-1:0]     op_a_q [NSEG];
   logic [WIDTH-1:0]     op_a_d [NSEG];
   logic [WIDTH-1:0]     op_b_q [NSEG];
   logic [WIDTH-1:0]     op_b_d [NSEG];
   logic [WIDTH-1:0]     sum_q  [NSEG];
   logic [WIDTH-1:0]     sum_d  [NSEG];
   logic [NSEG-1:0]      cy_q, cy_d;
   logic [NSEG-1:0]      ov_q, ov_d;
   logic [NSEG-1:0]      vld_q, vld_d;
   logic [SEG_WIDTH+1:0] seg_r  [NSEG];

   logic             advance;
   logic [WIDTH-1:0] b_eff;
   logic             cin0;

   assign advance  = ~vld_q[NSEG-1] | out_ready;
   assign in_ready = advance;

   // Subtraction is a + ~b + 1: B is inverted once at capture and the
   // rank-0 carry-in is forced to 1 (c is ignored).
   assign b_eff = sub ? ~b : b;
   assign cin0  = sub | c;

   // Next contents of every rank: rank 0 adds segment 0 of the incoming
   // operands, rank k adds segment k of the beat held in rank k-1.
   always_comb begin
      cy_d  = '0;
      ov_d  = '0;
      vld_d = '0;
      for (int k = 0; k < NSEG; k++) begin
         op_a_d[k] = '0;
         op_b_d[k] = '0;
         sum_d[k]  = '0;
         seg_r[k]  = '0;
      end

      seg_r[0]                  = seg_add(a[SEG_WIDTH-1:0], b_eff[SEG_WIDTH-1:0], cin0);
      op_a_d[0]                 = a;
      op_b_d[0]                 = b_eff;
      sum_d[0][SEG_WIDTH-1:0]   = seg_r[0][SEG_WIDTH-1:0];
      cy_d[0]                   = seg_r[0][SEG_WIDTH];
      ov_d[0]                   = seg_r[0][SEG_WIDTH+1] ^ seg_r[0][SEG_WIDTH];
      vld_d[0]                  = in_valid;

      for (int k = 1; k < NSEG; k++) begin
         seg_r[k]  = seg_add(op_a_q[k-1][k*SEG_WIDTH +: SEG_WIDTH],
                             op_b_q[k-1][k*SEG_WIDTH +: SEG_WIDTH],
                             cy_q[k-1]);
         op_a_d[k] = op_a_q[k-1];
         op_b_d[k] = op_b_q[k-1];
         sum_d[k]  = sum_q[k-1];
         sum_d[k][k*SEG_WIDTH +: SEG_WIDTH] = seg_r[k][SEG_WIDTH-1:0];
         cy_d[k]   = seg_r[k][SEG_WIDTH];
         // Only the last rank's value reaches ovf; it is the carry into the
         // word MSB xor the carry out of the word MSB.
         ov_d[k]   = seg_r[k][SEG_WIDTH+1] ^ seg_r[k][SEG_WIDTH];
         vld_d[k]  = vld_q[k-1];
      end
   end

   // Pipeline registers: clear on reset, shift together on advance, else hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NSEG; k++) begin
            op_a_q[k] <= '0;
            op_b_q[k] <= '0;
            sum_q[k]  <= '0;
         end
         cy_q  <= '0;
         ov_q  <= '0;
         vld_q <= '0;
      end else if (advance) begin
         for (int k = 0; k < NSEG; k++) begin
            op_a_q[k] <= op_a_d[k];
            op_b_q[k] <= op_b_d[k];
            sum_q[k]  <= sum_d[k];
         end
         cy_q  <= cy_d;
         ov_q  <= ov_d;
         vld_q <= vld_d;
      end
   end

   // The last rank drives the outputs directly.
   assign out_valid = vld_q[NSEG-1];
   assign sum       = sum_q[NSEG-1];
   assign carry     = cy_q[NSEG-1];
   assign ovf       = ov_q[NSEG-1];

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Testbench for pipelined_segment_adder (WIDTH=16, SEG_WIDTH=4).
// Accepted beats are scored against a plain-arithmetic model and queued. A
// negedge monitor pops the queue on every output transfer and compares.
module tb_pipelined_segment_adder;

   localparam int W    = 16;
   localparam int NSEG = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         carry;
   logic         ovf;

   int errors = 0;
   int checks = 0;

   // Expected results, packed as {carry, ovf, sum}.
   logic [W+1:0] exp_q[$];
   logic [W+1:0] exp_v;
   logic         hold_prev = 1'b0;
   logic [W+1:0] held;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   pipelined_segment_adder #(.WIDTH(W), .SEG_WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c         (c),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry),
      .ovf       (ovf)
   );

   // ---------------- reference model ----------------
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci, input logic s);
      logic [W-1:0] yy;
      logic [W:0]   t;
      logic         v;
      yy = s ? ~y : y;
      t  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (s | ci)};
      // Signed overflow: operands of equal sign giving a result of the other sign.
      v  = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
      return {t[W], v, t[W-1:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         hold_prev = 1'b0;
      end else begin
         if (in_valid && in_ready) exp_q.push_back(model(a, b, c, sub));
         if (hold_prev) chk("hold_stable", {14'd0, carry, ovf, sum}, {14'd0, held});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: got %h expected no beat at %0t", {carry, ovf, sum}, $time);
            end else begin
               exp_v = exp_q.pop_front();
               chk("result", {14'd0, carry, ovf, sum}, {14'd0, exp_v});
            end
         end
         hold_prev = out_valid && !out_ready;
         held      = {carry, ovf, sum};
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until accepted (bounded).
   task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vc, input logic vs);
      logic done;
      done     = 1'b0;
      a        = va;
      b        = vb;
      c        = vc;
      sub      = vs;
      in_valid = 1'b1;
      #1;
      for (int n = 0; n < 50 && !done; n++) begin
         if (in_ready) done = 1'b1;
         step;
      end
      in_valid = 1'b0;
      chk("send_accepted", {31'd0, done}, 32'd1);
   endtask

   task automatic drain;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      #1;
      for (int n = 0; n < 60; n++) begin
         if (exp_q.size() == 0 && !out_valid) break;
         step;
      end
      chk("drain_empty", exp_q.size(), 32'd0);
   endtask

   // Single beat into an empty pipe: check latency and the exact result.
   task automatic directed(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic vc, input logic vs, input logic [W-1:0] e_sum,
                           input logic e_carry, input logic e_ovf);
      drain;
      chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      a        = va;
      b        = vb;
      c        = vc;
      sub      = vs;
      in_valid = 1'b1;
      step;               // acceptance edge
      in_valid = 1'b0;
      for (int i = 0; i < NSEG - 1; i++) begin
         chk({name, "_early_valid"}, {31'd0, out_valid}, 32'd0);
         step;
      end
      chk({name, "_out_valid"}, {31'd0, out_valid}, 32'd1);
      chk({name, "_sum"}, {16'd0, sum}, {16'd0, e_sum});
      chk({name, "_carry"}, {31'd0, carry}, {31'd0, e_carry});
      chk({name, "_ovf"}, {31'd0, ovf}, {31'd0, e_ovf});
      step;
   endtask

   function automatic logic [W-1:0] rand_op();
      logic [W-1:0] r;
      case ($urandom_range(0, 5))
         0: r = 16'hFFFF;
         1: r = 16'h0000;
         2: r = 16'h8000;
         3: r = 16'h7FFF;
         default: r = W'($urandom);
      endcase
      return r;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic acc;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      c         = 1'b0;
      sub       = 1'b0;
      repeat (2) step;
      rst = 1'b0;
      #1;
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_sum", {16'd0, sum}, 32'd0);
      chk("reset_carry", {31'd0, carry}, 32'd0);
      chk("reset_ovf", {31'd0, ovf}, 32'd0);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

      // Directed vectors.
      directed("basic",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
      directed("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      directed("cin",    16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
      directed("sub1",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      directed("sub2",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      // Streaming: 8 back-to-back beats, in_ready must stay high.
      drain;
      for (int i = 0; i < 8; i++) begin
         chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
         send(W'(i), W'(16'h0100 * i), 1'b0, 1'b0);
      end
      drain;

      // Backpressure: fill the pipe, then stall the output for 3 cycles.
      for (int i = 0; i < 4; i++) send(W'(16'h1111 * (i + 1)), W'(16'h0F0F + i), 1'b0, 1'b0);
      a         = 16'hABCD;
      b         = 16'h1357;
      c         = 1'b1;
      sub       = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         step;
      end
      out_ready = 1'b1;
      send(16'hABCD, 16'h1357, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("bp_drain_valid", {31'd0, out_valid}, 32'd1);
         step;
      end
      drain;

      // Randomized traffic with random backpressure.
      in_valid = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         out_ready = ($urandom_range(0, 9) < 7);
         if (!in_valid && $urandom_range(0, 3) != 0) begin
            a        = rand_op();
            b        = rand_op();
            c        = 1'($urandom_range(0, 1));
            sub      = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
         end
         #1;
         acc = in_valid && in_ready;
         step;
         if (acc) in_valid = 1'b0;
      end
      drain;

      // Reset with three beats in flight; in_valid held high during reset.
      send(16'h0101, 16'h0202, 1'b0, 1'b0);
      send(16'h0303, 16'h0404, 1'b0, 1'b0);
      send(16'h0505, 16'h0606, 1'b0, 1'b0);
      rst      = 1'b1;
      in_valid = 1'b1;
      a        = 16'hDEAD;
      b        = 16'hBEEF;
      exp_q.delete();
      step;
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_sum", {16'd0, sum}, 32'd0);
      chk("rst_mid_carry", {31'd0, carry}, 32'd0);
      chk("rst_mid_ovf", {31'd0, ovf}, 32'd0);
      chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         step;
         chk("rst_no_stale", {31'd0, out_valid}, 32'd0);
      end

      // One more beat after reset to show the pipe still works.
      send(16'h00FF, 16'h0001, 1'b0, 1'b0);
      drain;

      chk("final_queue_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
